// File: rtl/rvv_mem_responder.sv
// Data-memory responder for the vector core. Writes land immediately; reads go
// through a fixed-latency pipeline and a show-ahead FIFO, returned in order.
module rvv_mem_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int READ_LAT   = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic                  mem_wvalid_in,
    input  logic [DATA_WIDTH-1:0] mem_wdata_in,
    output logic                  mem_req_rdy_out,
    output logic [DATA_WIDTH-1:0] mem_rdata_out,
    output logic                  mem_rvalid_out,
    input  logic                  mem_rready_in
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RESP_DEPTH);

    // Handshakes: a read transfers at an edge where mem_req_in & mem_req_rdy_out,
    // a response transfers at an edge where mem_rvalid_out & mem_rready_in;
    // write beats (mem_wvalid_in) are always taken at the edge they are seen.
    logic                  accept;
    logic                  pop;
    logic [IDX_W-1:0]      word_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  push_vld;
    logic [DATA_WIDTH-1:0] push_data;

    logic [DATA_WIDTH-1:0] mem_array [MEM_DEPTH];

    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [CNT_W-1:0]      out_cnt;
    logic [DATA_WIDTH-1:0] last_rdata;

    logic addr_unused;
    assign addr_unused = ^{mem_addr_in[OFF_W-1:0], mem_addr_in[ADDR_WIDTH-1:OFF_W+IDX_W]};

    assign word_idx = mem_addr_in[OFF_W +: IDX_W];

    // The array is read combinationally before this edge's write lands, which
    // gives read-before-write on a same-edge collision.
    assign rd_word = mem_array[word_idx];

    always_ff @(posedge clk) begin
        if (mem_wvalid_in) begin
            mem_array[word_idx] <= mem_wdata_in;
        end
    end

    assign mem_req_rdy_out = (out_cnt < CNT_FULL);
    assign mem_rvalid_out  = (fifo_cnt != '0);
    assign accept          = mem_req_in & mem_req_rdy_out;
    assign pop             = mem_rvalid_out & mem_rready_in;

    // READ_LAT-1 register stages; the FIFO entry itself is the final stage.
    generate
        if (READ_LAT == 1) begin : g_direct
            assign push_vld  = accept;
            assign push_data = rd_word;
        end else begin : g_pipe
            logic [DATA_WIDTH-1:0] stg_data [READ_LAT-1];
            logic                  stg_vld  [READ_LAT-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < READ_LAT - 1; i++) begin
                        stg_vld[i] <= 1'b0;
                    end
                end else begin
                    stg_vld[0] <= accept;
                    for (int i = 1; i < READ_LAT - 1; i++) begin
                        stg_vld[i] <= stg_vld[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                stg_data[0] <= rd_word;
                for (int i = 1; i < READ_LAT - 1; i++) begin
                    stg_data[i] <= stg_data[i-1];
                end
            end

            assign push_vld  = stg_vld[READ_LAT-2];
            assign push_data = stg_data[READ_LAT-2];
        end
    endgenerate

    // Outstanding count covers pipeline plus FIFO, so a push always has room.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_vld, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // Tracks the head so the data bus keeps its last value once the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_rdata <= '0;
        end else if (mem_rvalid_out) begin
            last_rdata <= fifo_mem[rd_ptr];
        end
    end

    assign mem_rdata_out = mem_rvalid_out ? fifo_mem[rd_ptr] : last_rdata;

endmodule

// File: tb/tb_rvv_mem_responder.sv
// Directed bench for rvv_mem_responder: latency, collisions, backpressure,
// streaming, address wrap and mid-flight reset, with hand-computed expectations.
module tb_rvv_mem_responder;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic          mem_req_in;
    logic [AW-1:0] mem_addr_in;
    logic          mem_wvalid_in;
    logic [DW-1:0] mem_wdata_in;
    logic          mem_req_rdy_out;
    logic [DW-1:0] mem_rdata_out;
    logic          mem_rvalid_out;
    logic          mem_rready_in;

    int checks = 0;
    int errors = 0;

    rvv_mem_responder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MEM_DEPTH (1024),
        .READ_LAT  (2),
        .RESP_DEPTH(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_in     (mem_req_in),
        .mem_addr_in    (mem_addr_in),
        .mem_wvalid_in  (mem_wvalid_in),
        .mem_wdata_in   (mem_wdata_in),
        .mem_req_rdy_out(mem_req_rdy_out),
        .mem_rdata_out  (mem_rdata_out),
        .mem_rvalid_out (mem_rvalid_out),
        .mem_rready_in  (mem_rready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        mem_wvalid_in = 1'b1;
        mem_addr_in   = addr;
        mem_wdata_in  = data;
        tick();
        mem_wvalid_in = 1'b0;
    endtask

    // Single read with an empty FIFO and rready=1: valid two edges after issue.
    task automatic rd(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        mem_req_in  = 1'b1;
        mem_addr_in = addr;
        tick();
        mem_req_in = 1'b0;
        tick();
        check({tag, "_vld"}, DW'(mem_rvalid_out), DW'(1));
        check({tag, "_data"}, mem_rdata_out, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        mem_req_in    = 1'b0;
        mem_addr_in   = '0;
        mem_wvalid_in = 1'b0;
        mem_wdata_in  = '0;
        mem_rready_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rvalid", DW'(mem_rvalid_out), DW'(0));
        check("rst_rdata", mem_rdata_out, DW'(0));
        check("rst_rdy", DW'(mem_req_rdy_out), DW'(1));

        // Basic write then read, latency of exactly two edges
        wr(32'h10, 64'hDEAD_BEEF_0000_0001);
        mem_req_in  = 1'b1;
        mem_addr_in = 32'h10;
        tick();
        mem_req_in = 1'b0;
        check("lat_early_vld", DW'(mem_rvalid_out), DW'(0));
        check("lat_rdy1", DW'(mem_req_rdy_out), DW'(1));
        tick();
        check("lat_vld", DW'(mem_rvalid_out), DW'(1));
        check("lat_data", mem_rdata_out, 64'hDEAD_BEEF_0000_0001);
        check("lat_rdy2", DW'(mem_req_rdy_out), DW'(1));
        tick();
        check("lat_drain_vld", DW'(mem_rvalid_out), DW'(0));
        check("lat_hold_data", mem_rdata_out, 64'hDEAD_BEEF_0000_0001);

        // Same-edge read and write: old data first, new data afterwards
        wr(32'h20, 64'h5);
        mem_req_in    = 1'b1;
        mem_wvalid_in = 1'b1;
        mem_addr_in   = 32'h20;
        mem_wdata_in  = 64'hA;
        tick();
        mem_req_in    = 1'b0;
        mem_wvalid_in = 1'b0;
        tick();
        check("rbw_vld", DW'(mem_rvalid_out), DW'(1));
        check("rbw_old", mem_rdata_out, 64'h5);
        tick();
        rd("rbw_new", 32'h20, 64'hA);

        // Backpressure: six back-to-back requests, only four fit
        for (int i = 0; i < 6; i++) wr(32'h40 + 32'(8 * i), 64'h100 + 64'(i));
        mem_rready_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mem_req_in  = 1'b1;
            mem_addr_in = (k < 4) ? 32'h40 + 32'(8 * k) : 32'h60;
            check($sformatf("bp_rdy_%0d", k), DW'(mem_req_rdy_out), DW'(k < 4));
            tick();
        end
        check("bp_vld", DW'(mem_rvalid_out), DW'(1));
        check("bp_head", mem_rdata_out, 64'h100);
        check("bp_rdy_low", DW'(mem_req_rdy_out), DW'(0));
        tick();
        check("bp_head_held", mem_rdata_out, 64'h100);
        mem_rready_in = 1'b1;
        tick();
        check("bp_r1", mem_rdata_out, 64'h101);
        check("bp_rdy_back", DW'(mem_req_rdy_out), DW'(1));
        tick();
        mem_addr_in = 32'h68;
        check("bp_r2", mem_rdata_out, 64'h102);
        tick();
        mem_req_in = 1'b0;
        check("bp_r3", mem_rdata_out, 64'h103);
        tick();
        check("bp_r4", mem_rdata_out, 64'h104);
        tick();
        check("bp_r5", mem_rdata_out, 64'h105);
        check("bp_r5_vld", DW'(mem_rvalid_out), DW'(1));
        tick();
        check("bp_empty", DW'(mem_rvalid_out), DW'(0));
        check("bp_empty_hold", mem_rdata_out, 64'h105);

        // Streaming: one accept per cycle, responses with no bubbles
        for (int i = 0; i < 16; i++) wr(32'(8 * i), 64'h1000 + 64'(i));
        for (int k = 0; k < 16; k++) begin
            mem_req_in  = 1'b1;
            mem_addr_in = 32'(8 * k);
            check($sformatf("st_rdy_%0d", k), DW'(mem_req_rdy_out), DW'(1));
            tick();
            if (k == 0) begin
                check("st_first_vld", DW'(mem_rvalid_out), DW'(0));
            end else begin
                check($sformatf("st_vld_%0d", k - 1), DW'(mem_rvalid_out), DW'(1));
                check($sformatf("st_data_%0d", k - 1), mem_rdata_out, 64'h1000 + 64'(k - 1));
            end
        end
        mem_req_in = 1'b0;
        tick();
        check("st_vld_15", DW'(mem_rvalid_out), DW'(1));
        check("st_data_15", mem_rdata_out, 64'h100F);
        tick();
        check("st_done", DW'(mem_rvalid_out), DW'(0));

        // Address wrap and ignored byte-offset bits
        wr(32'h2018, 64'h3333_4444_5555_6666);
        rd("wrap_w3", 32'h18, 64'h3333_4444_5555_6666);
        rd("wrap_lowbits", 32'h1B, 64'h3333_4444_5555_6666);

        // Reset with three reads outstanding
        mem_rready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_req_in  = 1'b1;
            mem_addr_in = 32'(8 * k);
            tick();
        end
        mem_req_in = 1'b0;
        tick();
        check("pre_rst_vld", DW'(mem_rvalid_out), DW'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_vld", DW'(mem_rvalid_out), DW'(0));
        check("mid_rst_rdy", DW'(mem_req_rdy_out), DW'(1));
        check("mid_rst_rdata", mem_rdata_out, DW'(0));
        mem_rready_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("no_stale_%0d", k), DW'(mem_rvalid_out), DW'(0));
        end
        rd("survive_w3", 32'h18, 64'h3333_4444_5555_6666);
        rd("survive_w1", 32'h8, 64'h1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvv_mem_responder.md
Name: rvv_mem_responder

Overview:
- Memory-side responder for the vector processor's data memory port.
- Accepts read requests and write beats from the processor on a shared address bus and holds a synchronous word-addressed memory array.
- Returns read data in order through a fixed-latency pipeline and a response FIFO, with ready/valid backpressure.
- Used as the memory model in simulation and as on-chip data RAM on FPGA builds.

Parameters:
- DATA_WIDTH, 64, width of one memory word and of the data buses.
- ADDR_WIDTH, 32, byte-address width.
- MEM_DEPTH, 1024, number of words; must be a power of 2.
- READ_LAT, 2, cycles from request acceptance to earliest response valid; must be ≥ 1.
- RESP_DEPTH, 4, response FIFO entries and maximum outstanding reads; must be a power of 2, ≥ 2.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- mem_req_in, input, 1, read request valid.
- mem_addr_in, input, ADDR_WIDTH, byte address shared by reads and writes.
- mem_wvalid_in, input, 1, write beat valid.
- mem_wdata_in, input, DATA_WIDTH, write data.
- mem_req_rdy_out, output, 1, read request can be accepted this cycle.
- mem_rdata_out, output, DATA_WIDTH, read response data.
- mem_rvalid_out, output, 1, read response valid.
- mem_rready_in, input, 1, processor accepts the response this cycle.

Behaviour:
- Reset: synchronous, active-high on rst. Clears pipeline valid bits, FIFO pointers and outstanding counter. Array contents are not reset. After reset, mem_rvalid_out=0, mem_rdata_out=0, mem_req_rdy_out=1. Reset mid-operation drops all in-flight reads and buffered responses silently.
- Addressing: word index = mem_addr_in[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]. Low byte-offset bits are ignored (no misalignment error). Upper bits are ignored, so addresses wrap modulo MEM_DEPTH words.
- Write: when mem_wvalid_in=1 at a rising edge, the word is written at that edge. Writes are always accepted and never backpressured. Full-word writes only.
- Read accept: a read is accepted at the edge where mem_req_in=1 and mem_req_rdy_out=1. A request while mem_req_rdy_out=0 is ignored; the processor must hold it.
- Read/write collision: if mem_req_in and mem_wvalid_in are both high at the same edge (same address), the read returns the old data (read-before-write). A read accepted at edge T is unaffected by writes at edges after T.
- Outstanding counter: outstanding = reads in the pipeline + FIFO occupancy, width log2(RESP_DEPTH)+1.
  - +1 on accept, −1 on pop (mem_rvalid_out & mem_rready_in). Both in one cycle leaves it unchanged.
  - mem_req_rdy_out = (outstanding < RESP_DEPTH). This is registered-state-derived, with no combinational path from mem_req_in or mem_rready_in.
  - A pop does not raise rdy in the same cycle.
- Pipeline: the array is read at acceptance edge T. Data shifts through READ_LAT−1 further register stages, each with a valid bit, then enters the FIFO. A FIFO write can never overflow, because the counter guarantees space.
- Response: show-ahead FIFO. mem_rvalid_out = FIFO non-empty; mem_rdata_out = head entry.
  - With an empty FIFO and no stalls, a read accepted at edge T gives valid during the cycle after edge T+READ_LAT−1, i.e. READ_LAT cycles after acceptance.
  - While mem_rvalid_out=1 and mem_rready_in=0, mem_rdata_out is held stable.
  - Responses are returned strictly in request order.
  - mem_rdata_out holds its last value when the FIFO is empty.
- Simultaneous push and pop on a full FIFO is legal: occupancy is unchanged. Pointers wrap modulo RESP_DEPTH.
- Throughput: with mem_rready_in held at 1, one read is accepted per cycle indefinitely, provided RESP_DEPTH > READ_LAT.

Test Plan:
- Reset then write 0xDEAD_BEEF_0000_0001 to addr 0x10, read addr 0x10 -> mem_rvalid_out high exactly READ_LAT=2 cycles after accept, data matches; mem_req_rdy_out=1 throughout.
- Same-edge read+write to addr 0x20 (old 0x5, new 0xA) -> response 0x5; a subsequent read returns 0xA.
- rready held 0, issue 6 back-to-back reads -> exactly 4 accepted, mem_req_rdy_out drops after the 4th; rdata stays on the first response. Release rready -> 4 responses in order, then the remaining 2 are accepted.
- Streaming 16 reads to addrs 0x0..0x78 with rready=1 -> one accept per cycle, 16 in-order responses, no bubbles after the first.
- Address wrap: write at word index MEM_DEPTH+3 (byte addr (1024+3)*8) then read word 3 -> same data; low-bit addr 0x1B reads word 3.
- Assert rst with 3 reads outstanding -> next cycle mem_rvalid_out=0, mem_req_rdy_out=1, no stale responses appear; array data survives.
